// File: rtl/rgb_hue_sequencer_if.sv
// Control and LED bundle for the hue sequencer: controls flow master->slave and PWM/status flow back.
interface rgb_hue_sequencer_if #(
    parameter int PWM_BITS = 8
);
    logic                enable;
    logic                mode;
    logic                dir;
    logic [PWM_BITS-1:0] brightness;
    logic                red;
    logic                green;
    logic                blue;
    logic [2:0]          sector;
    logic                wrap;

    modport master (
        output enable, mode, dir, brightness,
        input  red, green, blue, sector, wrap
    );

    modport slave (
        input  enable, mode, dir, brightness,
        output red, green, blue, sector, wrap
    );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Six-sector hue wheel walker with hard-step or cross-fade colour and per-channel PWM.
// Duty registers reload only at the PWM period boundary, so each period is glitch-free.
module rgb_hue_sequencer #(
    parameter int PWM_BITS = 8,
    parameter int TICK_DIV = 46875
) (
    input logic                clk,
    input logic                reset,
    rgb_hue_sequencer_if.slave bus
);
    localparam int                  PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int                  PROD_W   = 2 * PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] phase_q, phase_d;
    logic [2:0]          sector_q, sector_d;
    logic                wrap_q, wrap_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_r_q, duty_g_q, duty_b_q;
    logic                red_q, green_q, blue_q;
    logic [PWM_BITS-1:0] lvl_r, lvl_g, lvl_b;
    logic [PWM_BITS-1:0] up, dn;
    logic                tick;

    // (level * (brightness+1)) >> PWM_BITS, so full brightness is transparent and zero is dark
    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] lvl,
                                                  input logic [PWM_BITS-1:0] br);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(lvl) * (PROD_W'(br) + PROD_W'(1));
        return PWM_BITS'(prod >> PWM_BITS);
    endfunction

    assign tick = bus.enable && (presc_q == PRE_LAST);

    always_comb begin
        presc_d  = presc_q;
        phase_d  = phase_q;
        sector_d = sector_q;
        wrap_d   = 1'b0;
        if (bus.enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            if (!bus.dir) begin
                if (phase_q == MAX) begin
                    phase_d = '0;
                    if (sector_q == 3'd5) begin
                        sector_d = 3'd0;
                        wrap_d   = 1'b1;
                    end else begin
                        sector_d = sector_q + 3'd1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end else begin
                if (phase_q == '0) begin
                    phase_d = MAX;
                    if (sector_q == 3'd0) begin
                        sector_d = 3'd5;
                        wrap_d   = 1'b1;
                    end else begin
                        sector_d = sector_q - 3'd1;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
        end
    end

    assign up = phase_q;
    assign dn = MAX - phase_q;

    always_comb begin
        lvl_r = '0;
        lvl_g = '0;
        lvl_b = '0;
        if (bus.mode) begin
            case (sector_q)
                3'd0:    begin lvl_r = MAX; lvl_g = up;  lvl_b = '0;  end
                3'd1:    begin lvl_r = dn;  lvl_g = MAX; lvl_b = '0;  end
                3'd2:    begin lvl_r = '0;  lvl_g = MAX; lvl_b = up;  end
                3'd3:    begin lvl_r = '0;  lvl_g = dn;  lvl_b = MAX; end
                3'd4:    begin lvl_r = up;  lvl_g = '0;  lvl_b = MAX; end
                3'd5:    begin lvl_r = MAX; lvl_g = '0;  lvl_b = dn;  end
                default: begin lvl_r = '0;  lvl_g = '0;  lvl_b = '0;  end
            endcase
        end else begin
            case (sector_q)
                3'd0:    begin lvl_r = MAX; lvl_g = '0;  lvl_b = '0;  end
                3'd1:    begin lvl_r = MAX; lvl_g = MAX; lvl_b = '0;  end
                3'd2:    begin lvl_r = '0;  lvl_g = MAX; lvl_b = '0;  end
                3'd3:    begin lvl_r = '0;  lvl_g = MAX; lvl_b = MAX; end
                3'd4:    begin lvl_r = '0;  lvl_g = '0;  lvl_b = MAX; end
                3'd5:    begin lvl_r = MAX; lvl_g = '0;  lvl_b = MAX; end
                default: begin lvl_r = '0;  lvl_g = '0;  lvl_b = '0;  end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            phase_q   <= '0;
            sector_q  <= 3'd0;
            wrap_q    <= 1'b0;
            pwm_cnt_q <= '0;
            duty_r_q  <= '0;
            duty_g_q  <= '0;
            duty_b_q  <= '0;
            red_q     <= 1'b0;
            green_q   <= 1'b0;
            blue_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            sector_q  <= sector_d;
            wrap_q    <= wrap_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (pwm_cnt_q == MAX) begin
                duty_r_q <= scale(lvl_r, bus.brightness);
                duty_g_q <= scale(lvl_g, bus.brightness);
                duty_b_q <= scale(lvl_b, bus.brightness);
            end
            red_q   <= (pwm_cnt_q < duty_r_q);
            green_q <= (pwm_cnt_q < duty_g_q);
            blue_q  <= (pwm_cnt_q < duty_b_q);
        end
    end

    assign bus.red    = red_q;
    assign bus.green  = green_q;
    assign bus.blue   = blue_q;
    assign bus.sector = sector_q;
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Directed bench for the hue sequencer with PWM_BITS=4, TICK_DIV=2 (one phase step per two clocks).
module tb_rgb_hue_sequencer;
    localparam int PB = 4;
    localparam int TD = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   nvec  = 0;
    int   nfail = 0;
    int   cr, cg, cb, w;

    // Per 16-cycle window in hard mode, full brightness: {R,G,B} channels expected on
    logic [2:0] hard_exp [13] = '{3'b000, 3'b100, 3'b100, 3'b110, 3'b110, 3'b010, 3'b010,
                                  3'b011, 3'b011, 3'b001, 3'b001, 3'b101, 3'b101};

    rgb_hue_sequencer_if #(.PWM_BITS(PB)) bif ();

    rgb_hue_sequencer #(.PWM_BITS(PB), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic m, input logic d, input logic [PB-1:0] br);
        reset          = 1'b0;
        bif.enable     = 1'b1;
        bif.mode       = m;
        bif.dir        = d;
        bif.brightness = br;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Count high cycles of each channel over the next 16 edges
    task automatic window(input string tag, input int er, input int eg, input int eb);
        int r = 0;
        int g = 0;
        int b = 0;
        for (int i = 0; i < 16; i++) begin
            edge1();
            r += int'(bif.red);
            g += int'(bif.green);
            b += int'(bif.blue);
        end
        chk({tag, "_red"}, r, er);
        chk({tag, "_green"}, g, eg);
        chk({tag, "_blue"}, b, eb);
    endtask

    initial begin
        bif.enable     = 1'b1;
        bif.mode       = 1'b0;
        bif.dir        = 1'b0;
        bif.brightness = 4'd15;
        #12;
        chk("rst_red", bif.red, 0);
        chk("rst_green", bif.green, 0);
        chk("rst_blue", bif.blue, 0);
        chk("rst_sector", bif.sector, 0);
        chk("rst_wrap", bif.wrap, 0);

        // Hard step, forward, full brightness: full wheel plus one window
        restart(1'b0, 1'b0, 4'd15);
        cr = 0; cg = 0; cb = 0;
        for (int e = 1; e <= 208; e++) begin
            edge1();
            chk("hard_sector", bif.sector, (e / 32) % 6);
            chk("hard_wrap", bif.wrap, (e == 192) ? 1 : 0);
            cr += int'(bif.red);
            cg += int'(bif.green);
            cb += int'(bif.blue);
            if (e % 16 == 0) begin
                w = e / 16 - 1;
                chk("hard_win_red", cr, hard_exp[w][2] ? 15 : 0);
                chk("hard_win_green", cg, hard_exp[w][1] ? 15 : 0);
                chk("hard_win_blue", cb, hard_exp[w][0] ? 15 : 0);
                cr = 0; cg = 0; cb = 0;
            end
        end

        // Fade, brightness 7, frozen at sector 0 phase 8
        restart(1'b1, 1'b0, 4'd7);
        repeat (16) edge1();
        bif.enable = 1'b0;
        chk("frz_sector0", bif.sector, 0);
        window("frz1", 7, 3, 0);
        window("frz2", 7, 4, 0);
        window("frz3", 7, 4, 0);
        chk("frz_sector1", bif.sector, 0);
        chk("frz_wrap", bif.wrap, 0);

        // Reverse from reset, fade, full brightness
        restart(1'b1, 1'b1, 4'd15);
        edge1();
        chk("rev_sector_e1", bif.sector, 0);
        chk("rev_wrap_e1", bif.wrap, 0);
        edge1();
        chk("rev_sector_e2", bif.sector, 5);
        chk("rev_wrap_e2", bif.wrap, 1);
        edge1();
        chk("rev_sector_e3", bif.sector, 5);
        chk("rev_wrap_e3", bif.wrap, 0);
        repeat (13) edge1();
        window("rev1", 15, 0, 6);
        window("rev2", 15, 0, 14);
        chk("rev_sector_e48", bif.sector, 4);
        window("rev3", 9, 0, 15);

        // Brightness zero blanks everything while the wheel still turns
        restart(1'b1, 1'b0, 4'd0);
        window("dark1", 0, 0, 0);
        window("dark2", 0, 0, 0);
        window("dark3", 0, 0, 0);
        chk("dark_sector", bif.sector, 1);
        bif.mode = 1'b0;
        window("dark4", 0, 0, 0);

        // Asynchronous reset between clock edges while red is high
        restart(1'b0, 1'b0, 4'd15);
        repeat (40) edge1();
        chk("arst_pre_red", bif.red, 1);
        chk("arst_pre_sector", bif.sector, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_red", bif.red, 0);
        chk("arst_green", bif.green, 0);
        chk("arst_blue", bif.blue, 0);
        chk("arst_sector", bif.sector, 0);
        chk("arst_wrap", bif.wrap, 0);
        @(negedge clk);
        reset = 1'b1;
        window("arst0", 0, 0, 0);
        window("arst1", 15, 0, 0);
        chk("arst_sector_e32", bif.sector, 1);
        window("arst2", 15, 0, 0);
        window("arst3", 15, 15, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/rgb_hue_sequencer.md
Name: rgb_hue_sequencer

Overview:
Parametrised RGB colour sequencer that walks the six-sector hue wheel: red, yellow, green, cyan, blue, magenta, then back to red.
- Two modes: hard step between the six colours, or a smooth linear cross-fade within each sector.
- Supports forward/reverse direction, pause, and global brightness scaling.
- Drives each channel with a free-running PWM.
- Sits between the board pins and the top level, replacing the one-hot shift-register colour cycler. Outputs are active-high; the top level inverts them for the active-low LED pins.

Parameters:
PWM_BITS, 8, PWM/phase/brightness resolution; MAX = 2^PWM_BITS-1
TICK_DIV, 46875, clk cycles per phase step (>=1); full wheel period = 6*(MAX+1)*TICK_DIV cycles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = sequence advances; 0 = freeze sector/phase (PWM keeps running)
mode  in  1  0 = hard step, 1 = cross-fade
dir  in  1  0 = forward (sector increments), 1 = reverse
brightness  in  PWM_BITS  global intensity, 0 = off, MAX = full
red  out  1  PWM red, active-high
green  out  1  PWM green, active-high
blue  out  1  PWM blue, active-high
sector  out  3  current hue sector 0..5
wrap  out  1  one-cycle pulse when sector wraps (5->0 forward, 0->5 reverse)

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0, phase=0, sector=0, pwm_cnt=0, duty_r/g/b=0, red/green/blue=0, wrap=0. Asserting reset mid-operation forces these values immediately, without waiting for clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1; holds its value while enable=0.
  - tick = (prescaler==TICK_DIV-1) && enable. On tick the prescaler returns to 0.
- Phase/sector on tick:
  - Forward: if phase==MAX then phase<=0 and sector<=(sector==5)?0:sector+1; else phase<=phase+1.
  - Reverse: if phase==0 then phase<=MAX and sector<=(sector==0)?5:sector-1; else phase<=phase-1.
  - wrap=1 in the cycle after a tick that moves sector 5->0 (forward) or 0->5 (reverse); 0 otherwise.
  - dir is sampled at each tick. A dir change between ticks takes effect at the next tick.
- Channel level (combinational from sector, phase, mode). F=MAX, Z=0, U=phase, D=MAX-phase; order R,G,B:
  - Fade (mode=1): s0 F,U,Z; s1 D,F,Z; s2 Z,F,U; s3 Z,D,F; s4 U,Z,F; s5 F,Z,D. The wheel is continuous across the 5->0 boundary.
  - Hard (mode=0): s0 F,Z,Z; s1 F,F,Z; s2 Z,F,Z; s3 Z,F,F; s4 Z,Z,F; s5 F,Z,F. Phase is ignored.
- Brightness scaling: duty = (level * (brightness+1)) >> PWM_BITS.
  - Product width 2*PWM_BITS+1; result truncated to PWM_BITS.
  - brightness=MAX gives duty=level; brightness=0 gives duty=0 for every level.
- PWM:
  - pwm_cnt is free-running 0..MAX and wraps.
  - duty_r/g/b registers load the scaled values only in the cycle where pwm_cnt==MAX, so no period is glitched mid-way.
  - Changes to mode, brightness, or sector take effect on PWM output at the next period boundary.
- Outputs: red/green/blue are registered; red <= (pwm_cnt < duty_r), same for green and blue.
  - Duty MAX gives high for MAX of every MAX+1 cycles; duty 0 gives always low.
  - After reset the first PWM period is all low, because duty_r/g/b are 0 until the first load.
- Simultaneous events: a tick coinciding with pwm_cnt==MAX uses the pre-tick sector/phase for that duty load.
- enable=0 never stops the PWM and never clears the outputs.

Test Plan:
1. PWM_BITS=4, TICK_DIV=2, mode=0, brightness=15, enable=1, dir=0, release reset -> red all low for 16 cycles, then high 15 of every 16 cycles; green=blue=0; sector=0 for 32 cycles after reset, then 1 (yellow: red and green both 15/16 duty).
2. Same config, run 192 cycles -> sector sequence 0,1,2,3,4,5 every 32 cycles; then 5->0 with a one-cycle wrap=1 pulse; no wrap pulse on the other transitions.
3. mode=1, brightness=7, freeze with enable=0 at sector=0, phase=8 -> duty_g = 8*8>>4 = 4 (green high 4/16 cycles); duty_r = 15*8>>4 = 7; blue=0; sector/phase stay constant for the whole time enable=0.
4. dir=1 from reset -> first tick sets sector=5, phase=15 with wrap=1; phase then counts down 14,13,… toward 0 on subsequent ticks.
5. brightness=0 in either mode -> red=green=blue=0 for all cycles after the next period boundary; sector keeps advancing.
6. Assert reset asynchronously mid-period, between clk edges, with red=1 -> red/green/blue=0, sector=0, wrap=0 immediately; normal sequence restarts as in scenario 1 after release.
